ex_acc_stage: RTL and testbench
===============================

Name: ex_acc_stage

Overview:
Execute/accumulator stage directly downstream of the MEM->EX pipeline register; consumes its registered data, opcode and write-enable controls.
Holds the architectural accumulator, carry and halt state, and performs ADD/AND/XOR/LDA.
Generates single-cycle skip, jump and store requests back to fetch and data memory.
One-cycle latency from an accepted instruction to the updated outputs.

Parameters:
DATA_W, 8, datapath and accumulator width (the opcode width is fixed at 3)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
data_in  in  DATA_W  operand / jump target from the MEM->EX register
mem_we  in  1  store request from MEM->EX
acc_we  in  1  accumulator write enable
acc_control  in  1  accumulator source select: 1 = ALU result, 0 = data_in
opcode  in  3  HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111
flush  in  1  squash the instruction presented this cycle
resume  in  1  leave HALT
acc_out  out  DATA_W  accumulator register
zero  out  1  (acc_out == 0), combinational from the register
carry  out  1  carry flag register
skip  out  1  one-cycle skip-next pulse
jump  out  1  one-cycle jump pulse
jump_target  out  DATA_W  registered target, valid while jump=1
store_we  out  1  one-cycle data-memory write pulse
store_data  out  DATA_W  registered store value
halted  out  1  high in the HALT state

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - acc_out=0, zero=1, carry=0.
  - skip, jump, store_we, halted all 0.
  - jump_target=0, store_data=0; state=RUN.
- State machine, two states:
  - RUN -> HALT: an active HLT.
  - HALT -> RUN: resume=1 sampled at a clock edge.
- Active instruction: state==RUN && !flush.
  - Inactive cycle: acc and carry hold; skip, jump and store_we are 0 at the next edge.
  - jump_target and store_data hold.
- In HALT, all inputs except resume and rst are ignored. The instruction presented in the resume cycle is also ignored.
- flush and HLT in the same cycle: flush wins, no halt.
- ALU (combinational):
  - ADD: 9-bit sum acc + data_in; result = sum[7:0], cout = sum[8].
  - AND: result = acc & data_in.
  - XOR: result = acc ^ data_in.
  - Every other opcode: result = data_in.
- Accumulator write: if active && acc_we, acc <= (acc_control ? ALU result : data_in), for any opcode.
- Carry update: only when active && acc_we && acc_control && opcode==ADD (carry <= cout). Otherwise carry holds.
- SKZ: skip <= (acc_out==0), using the pre-edge accumulator value.
- JMP: jump <= 1, jump_target <= data_in.
- STO:
  - store_we <= mem_we.
  - store_data <= pre-edge acc_out, so a same-cycle accumulator write is not visible.
  - mem_we on any opcode other than STO is ignored.
- All pulses are 1 for exactly one cycle per active instruction. Back-to-back identical instructions give consecutive pulses.
- Wrap-around: ADD wraps modulo 2^DATA_W, with carry set.

Optional Feature:
- Macro ACC_SAT_EN, defined: on an ADD with cout=1, the accumulator written is all ones (0xFF); carry is still set to 1.
- Macro ACC_SAT_EN, undefined: wrapping add as specified above.
- AND, XOR and LDA are unaffected either way.

Decomposition:
- Shared package cpu_pkg:
  - opcode_t enum (3-bit, encodings as listed under Ports).
  - ex_state_t enum {RUN, HALT}.
  - DATA_W default constant.
- One natural sub-module: acc_alu, combinational. Inputs: opcode, acc, data_in. Outputs: result, cout. Contains the ACC_SAT_EN conditional.
- The stage instantiates acc_alu and holds all registers and the FSM.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> acc_out=0x00, zero=1, carry=0, halted=0, all pulses 0 without waiting for a clock edge.
- Load then add:
  - LDA data_in=0xF0 (acc_we=1, acc_control=0) -> acc_out=0xF0.
  - Then ADD data_in=0x20 (acc_control=1) -> acc_out=0x10, carry=1.
  - With ACC_SAT_EN -> acc_out=0xFF, carry=1.
- Skip:
  - acc=0x00, SKZ -> skip=1 for exactly one cycle.
  - LDA 0x01 then SKZ -> skip=0.
  - LDA 0x00 and SKZ in consecutive cycles -> SKZ sees the new value 0x00, skip=1.
- Store and jump:
  - acc=0x5A, STO with mem_we=1 -> store_we=1 for one cycle, store_data=0x5A.
  - STO with mem_we=0 -> store_we stays 0.
  - JMP data_in=0x3C -> jump=1 for one cycle, jump_target=0x3C.
- Halt and flush:
  - HLT -> halted=1; subsequent ADD 0x01 with acc_we=1 leaves acc unchanged.
  - resume=1 -> halted=0 next cycle; the ADD in the resume cycle is ignored.
  - HLT with flush=1 -> halted stays 0.
- Reset in HALT: acc=0x33, halted=1, assert rst -> acc_out=0x00 and halted=0 immediately. After release, LDA 0x07 -> acc_out=0x07.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the execute/accumulator stage: opcode and FSM state encodings.
// Build option ACC_SAT_EN (saturating ADD) is consumed by acc_alu.
// No clocked logic here.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ex_state_t;

endpackage

// File: rtl/acc_alu.sv
// Accumulator ALU: ADD/AND/XOR, anything else passes data_in through.
// Latency: combinational. Backpressure: none. Define ACC_SAT_EN to clamp an overflowing ADD to all ones.
module acc_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  opcode_t           opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] result,
  output logic              cout
);

  logic [DATA_W:0] w_sum;

  assign w_sum = {1'b0, acc} + {1'b0, data_in};

  always_comb begin
    result = data_in;
    cout   = 1'b0;
    case (opcode)
      OP_ADD: begin
        cout = w_sum[DATA_W];
`ifdef ACC_SAT_EN
        result = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
        result = w_sum[DATA_W-1:0];
`endif
      end
      OP_AND:  result = acc & data_in;
      OP_XOR:  result = acc ^ data_in;
      default: result = data_in;
    endcase
  end

endmodule

// File: rtl/ex_acc_stage.sv
// Execute stage: accumulator/carry/halt state plus one-cycle skip, jump and store pulses.
// Latency: 1 cycle from accepted instruction to outputs. Backpressure: none; HALT or flush discards the instruction.
// Build option ACC_SAT_EN selects saturating ADD inside acc_alu.
module ex_acc_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_we,
  input  logic              acc_we,
  input  logic              acc_control,
  input  logic [2:0]        opcode,
  input  logic              flush,
  input  logic              resume,
  output logic [DATA_W-1:0] acc_out,
  output logic              zero,
  output logic              carry,
  output logic              skip,
  output logic              jump,
  output logic [DATA_W-1:0] jump_target,
  output logic              store_we,
  output logic [DATA_W-1:0] store_data,
  output logic              halted
);

  ex_state_t         r_state;
  logic [DATA_W-1:0] r_acc;
  logic              r_carry;
  logic              r_skip;
  logic              r_jump;
  logic [DATA_W-1:0] r_jump_target;
  logic              r_store_we;
  logic [DATA_W-1:0] r_store_data;

  opcode_t           w_op;
  logic [DATA_W-1:0] w_result;
  logic              w_cout;

  assign w_op = opcode_t'(opcode);

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode  (w_op),
    .acc     (r_acc),
    .data_in (data_in),
    .result  (w_result),
    .cout    (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_acc         <= '0;
      r_carry       <= 1'b0;
      r_skip        <= 1'b0;
      r_jump        <= 1'b0;
      r_jump_target <= '0;
      r_store_we    <= 1'b0;
      r_store_data  <= '0;
    end else begin
      r_skip     <= 1'b0;
      r_jump     <= 1'b0;
      r_store_we <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (!flush) begin
            if (acc_we) begin
              r_acc <= acc_control ? w_result : data_in;
              if (acc_control && (w_op == OP_ADD)) begin
                r_carry <= w_cout;
              end
            end
            // Skip and store observe the accumulator as it was before this edge.
            case (w_op)
              OP_HLT: r_state <= ST_HALT;
              OP_SKZ: r_skip  <= (r_acc == '0);
              OP_JMP: begin
                r_jump        <= 1'b1;
                r_jump_target <= data_in;
              end
              OP_STO: begin
                r_store_we   <= mem_we;
                r_store_data <= r_acc;
              end
              default: ;
            endcase
          end
        end
        ST_HALT: begin
          if (resume) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign acc_out     = r_acc;
  assign zero        = (r_acc == '0);
  assign carry       = r_carry;
  assign skip        = r_skip;
  assign jump        = r_jump;
  assign jump_target = r_jump_target;
  assign store_we    = r_store_we;
  assign store_data  = r_store_data;
  assign halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_ex_acc_stage.sv
// Directed bench for ex_acc_stage; expected ADD overflow result follows ACC_SAT_EN.
module tb_ex_acc_stage;

  localparam int DATA_W = 8;
`ifdef ACC_SAT_EN
  localparam logic [7:0] EXP_ADD = 8'hFF;
`else
  localparam logic [7:0] EXP_ADD = 8'h10;
`endif

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              mem_we;
  logic              acc_we;
  logic              acc_control;
  logic [2:0]        opcode;
  logic              flush;
  logic              resume;
  logic [DATA_W-1:0] acc_out;
  logic              zero;
  logic              carry;
  logic              skip;
  logic              jump;
  logic [DATA_W-1:0] jump_target;
  logic              store_we;
  logic [DATA_W-1:0] store_data;
  logic              halted;

  int n_pass  = 0;
  int n_total = 0;

  ex_acc_stage #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .mem_we      (mem_we),
    .acc_we      (acc_we),
    .acc_control (acc_control),
    .opcode      (opcode),
    .flush       (flush),
    .resume      (resume),
    .acc_out     (acc_out),
    .zero        (zero),
    .carry       (carry),
    .skip        (skip),
    .jump        (jump),
    .jump_target (jump_target),
    .store_we    (store_we),
    .store_data  (store_data),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction, then let one rising edge consume it; return at edge+1.
  task automatic issue(input logic [2:0] op, input logic [7:0] din, input logic we,
                       input logic ctl, input logic mw, input logic fl, input logic rs);
    opcode = op; data_in = din; acc_we = we; acc_control = ctl;
    mem_we = mw; flush = fl; resume = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue(3'b101, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    issue(3'b101, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b010, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (jump !== 1'b1 || carry !== 1'b1) $display("FAIL pre_reset jump=%b carry=%b want 1 1", jump, carry);
    else n_pass++;
    #4 rst = 1'b1;
    #1;
    n_total++;
    if (acc_out !== 8'h00 || zero !== 1'b1) $display("FAIL reset_acc acc=%h zero=%b want 00 1", acc_out, zero);
    else n_pass++;
    n_total++;
    if (carry !== 1'b0 || halted !== 1'b0) $display("FAIL reset_flags carry=%b halted=%b want 0 0", carry, halted);
    else n_pass++;
    n_total++;
    if ({skip, jump, store_we} !== 3'b000 || jump_target !== 8'h00 || store_data !== 8'h00)
      $display("FAIL reset_pulses sjs=%b jt=%h sd=%h want 000 00 00", {skip, jump, store_we}, jump_target, store_data);
    else n_pass++;
    #2 rst = 1'b0;
  endtask

  task automatic test_load_add();
    issue(3'b101, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (acc_out !== 8'hF0) $display("FAIL lda_f0 acc=%h want f0", acc_out);
    else n_pass++;
    issue(3'b010, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (acc_out !== EXP_ADD || carry !== 1'b1) $display("FAIL add_wrap acc=%h carry=%b want %h 1", acc_out, carry, EXP_ADD);
    else n_pass++;
    issue(3'b101, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b011, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (acc_out !== 8'h0C || carry !== 1'b1) $display("FAIL and_op acc=%h carry=%b want 0c 1", acc_out, carry);
    else n_pass++;
    issue(3'b100, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (acc_out !== 8'hF3) $display("FAIL xor_op acc=%h want f3", acc_out);
    else n_pass++;
    issue(3'b010, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (acc_out !== 8'hF4 || carry !== 1'b0) $display("FAIL add_nocarry acc=%h carry=%b want f4 0", acc_out, carry);
    else n_pass++;
  endtask

  task automatic test_skip();
    issue(3'b101, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (skip !== 1'b1) $display("FAIL skz_zero skip=%b want 1", skip);
    else n_pass++;
    issue(3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (skip !== 1'b1) $display("FAIL skz_b2b skip=%b want 1", skip);
    else n_pass++;
    idle();
    n_total++;
    if (skip !== 1'b0) $display("FAIL skz_pulse_end skip=%b want 0", skip);
    else n_pass++;
    issue(3'b101, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (skip !== 1'b0) $display("FAIL skz_nonzero skip=%b want 0", skip);
    else n_pass++;
    issue(3'b101, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (skip !== 1'b1) $display("FAIL skz_after_lda skip=%b want 1", skip);
    else n_pass++;
  endtask

  task automatic test_store_jump();
    issue(3'b101, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b110, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (store_we !== 1'b1 || store_data !== 8'h5A || acc_out !== 8'h11)
      $display("FAIL sto_pre_edge we=%b sd=%h acc=%h want 1 5a 11", store_we, store_data, acc_out);
    else n_pass++;
    idle();
    n_total++;
    if (store_we !== 1'b0 || store_data !== 8'h5A) $display("FAIL sto_pulse_end we=%b sd=%h want 0 5a", store_we, store_data);
    else n_pass++;
    issue(3'b110, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (store_we !== 1'b0) $display("FAIL sto_no_we we=%b want 0", store_we);
    else n_pass++;
    issue(3'b010, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (store_we !== 1'b0) $display("FAIL memwe_non_sto we=%b want 0", store_we);
    else n_pass++;
    issue(3'b111, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (jump !== 1'b1 || jump_target !== 8'h3C) $display("FAIL jmp jump=%b jt=%h want 1 3c", jump, jump_target);
    else n_pass++;
    idle();
    n_total++;
    if (jump !== 1'b0 || jump_target !== 8'h3C) $display("FAIL jmp_end jump=%b jt=%h want 0 3c", jump, jump_target);
    else n_pass++;
  endtask

  task automatic test_halt_flush();
    issue(3'b101, 8'h42, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b101, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_total++;
    if (acc_out !== 8'h42) $display("FAIL flush_lda acc=%h want 42", acc_out);
    else n_pass++;
    issue(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (halted !== 1'b1) $display("FAIL hlt halted=%b want 1", halted);
    else n_pass++;
    issue(3'b010, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (acc_out !== 8'h42 || halted !== 1'b1) $display("FAIL halt_ignore acc=%h halted=%b want 42 1", acc_out, halted);
    else n_pass++;
    issue(3'b010, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (acc_out !== 8'h42 || halted !== 1'b0) $display("FAIL resume acc=%h halted=%b want 42 0", acc_out, halted);
    else n_pass++;
    issue(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_total++;
    if (halted !== 1'b0) $display("FAIL hlt_flush halted=%b want 0", halted);
    else n_pass++;
  endtask

  task automatic test_reset_in_halt();
    issue(3'b101, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (acc_out !== 8'h33 || halted !== 1'b1) $display("FAIL pre_rst_halt acc=%h halted=%b want 33 1", acc_out, halted);
    else n_pass++;
    #4 rst = 1'b1;
    #1;
    n_total++;
    if (acc_out !== 8'h00 || halted !== 1'b0) $display("FAIL rst_in_halt acc=%h halted=%b want 00 0", acc_out, halted);
    else n_pass++;
    #2 rst = 1'b0;
    issue(3'b101, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (acc_out !== 8'h07) $display("FAIL lda_after_rst acc=%h want 07", acc_out);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    opcode = 3'b101; data_in = 8'h00; acc_we = 1'b0; acc_control = 1'b0;
    mem_we = 1'b0; flush = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_load_add();
    test_skip();
    test_store_jump();
    test_halt_flush();
    test_reset_in_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
